// File: rtl/coinc_pkg.sv
// Shared types and constants for the coincidence window generator.
package coinc_pkg;

  localparam int CNT_W   = 8;
  localparam int COUNT_W = 16;
  localparam int MAX_CH  = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPEN    = 2'd1,
    HOLDOFF = 2'd2
  } chan_state_t;

  // Number of set bits in v, leaving out bit 'skip' (skip < 0 counts every bit).
  function automatic int count_ones(input logic [MAX_CH-1:0] v, input int skip);
    int n;
    n = 0;
    for (int k = 0; k < MAX_CH; k++) begin
      if (k != skip && v[k]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/coinc_window_gen_if.sv
// Channel inputs, window outputs and overlap counter of the window generator.
interface coinc_window_gen_if #(parameter int NUM_CH = 4);
  import coinc_pkg::*;

  logic               enable;
  logic [NUM_CH-1:0]  chan_valid;
  logic [NUM_CH-1:0]  win_open;
  logic [NUM_CH-1:0]  other_valid;
  logic [COUNT_W-1:0] coinc_count;

  modport master (
    output enable, chan_valid,
    input  win_open, other_valid, coinc_count
  );

  modport slave (
    input  enable, chan_valid,
    output win_open, other_valid, coinc_count
  );

endinterface

// File: rtl/coinc_chan_fsm.sv
// One channel: valid-edge detection and the IDLE/OPEN/HOLDOFF window timer.
module coinc_chan_fsm
  import coinc_pkg::*;
#(
  parameter int WIN_LEN     = 8,
  parameter int HOLDOFF_LEN = 4
) (
  input  logic entry_clock,
  input  logic reset_n,
  input  logic enable,
  input  logic chan_valid,
  output logic win_open
);

  localparam logic [CNT_W-1:0] WIN_LOAD  = CNT_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'((HOLDOFF_LEN > 0) ? HOLDOFF_LEN - 1 : 0);

  chan_state_t      state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             sample_q, prev_q, primed_q;
  logic             rise_det;

  // The first sample after reset seeds both stages, so a level already high is not an edge.
  always_ff @(posedge entry_clock or negedge reset_n) begin
    if (!reset_n) begin
      sample_q <= 1'b0;
      prev_q   <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      sample_q <= chan_valid;
      prev_q   <= primed_q ? sample_q : chan_valid;
      primed_q <= 1'b1;
    end
  end

  assign rise_det = sample_q & ~prev_q;

  always_ff @(posedge entry_clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Edges are only honoured from IDLE; nothing is remembered from OPEN or HOLDOFF.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (!enable) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (rise_det) begin
            state_next = OPEN;
            cnt_next   = WIN_LOAD;
          end
        end
        OPEN: begin
          if (cnt == '0) begin
            if (HOLDOFF_LEN == 0) begin
              state_next = IDLE;
            end else begin
              state_next = HOLDOFF;
              cnt_next   = HOLD_LOAD;
            end
          end else begin
            cnt_next = cnt - CNT_W'(1);
          end
        end
        HOLDOFF: begin
          if (cnt == '0) begin
            state_next = IDLE;
          end else begin
            cnt_next = cnt - CNT_W'(1);
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  assign win_open = (state == OPEN);

endmodule

// File: rtl/coinc_window_gen.sv
// Per-channel coincidence windows, "other channels open" flags and overlap-onset counter.
// Build option: define COINC_MAJORITY_EN to require MIN_OTHERS other open windows instead of one.
module coinc_window_gen
  import coinc_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int WIN_LEN     = 8,
  parameter int HOLDOFF_LEN = 4,
  parameter int MIN_OTHERS  = 2
) (
  input  logic              entry_clock,
  input  logic              reset_n,
  coinc_window_gen_if.slave bus
);

`ifdef COINC_MAJORITY_EN
  localparam int THRESH = MIN_OTHERS;
`else
  localparam int THRESH = 1;
`endif

  if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_num_ch
    $error("NUM_CH out of range");
  end
  if (WIN_LEN < 1 || WIN_LEN > 255) begin : g_bad_win_len
    $error("WIN_LEN out of range");
  end
  if (HOLDOFF_LEN < 0 || HOLDOFF_LEN > 255) begin : g_bad_holdoff_len
    $error("HOLDOFF_LEN out of range");
  end
  if (NUM_CH > 1 && (MIN_OTHERS < 1 || MIN_OTHERS > NUM_CH - 1)) begin : g_bad_min_others
    $error("MIN_OTHERS out of range");
  end

  logic [NUM_CH-1:0]  win_open;
  logic [NUM_CH-1:0]  other_next, other_q;
  logic               multi, multi_q;
  logic [COUNT_W-1:0] coinc_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    coinc_chan_fsm #(
      .WIN_LEN     (WIN_LEN),
      .HOLDOFF_LEN (HOLDOFF_LEN)
    ) u_chan (
      .entry_clock (entry_clock),
      .reset_n     (reset_n),
      .enable      (bus.enable),
      .chan_valid  (bus.chan_valid[g]),
      .win_open    (win_open[g])
    );
  end

  // Each flag counts only the other channels, so a channel never sees its own window.
  always_comb begin
    other_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      other_next[i] = (count_ones(MAX_CH'(win_open), i) >= THRESH);
    end
    multi = (count_ones(MAX_CH'(win_open), -1) >= 2);
  end

  always_ff @(posedge entry_clock or negedge reset_n) begin
    if (!reset_n) begin
      other_q <= '0;
      multi_q <= 1'b0;
      coinc_q <= '0;
    end else begin
      other_q <= bus.enable ? other_next : '0;
      multi_q <= multi;
      if (bus.enable && multi && !multi_q && (coinc_q != '1)) begin
        coinc_q <= coinc_q + COUNT_W'(1);
      end
    end
  end

  assign bus.win_open    = win_open;
  assign bus.other_valid = other_q;
  assign bus.coinc_count = coinc_q;

endmodule

// File: tb/tb_coinc_window_gen.sv
// Directed bench for coinc_window_gen; window openings are scoreboarded, the rest checked in line.
module tb_coinc_window_gen;
  import coinc_pkg::*;

  localparam int NUM_CH      = 4;
  localparam int WIN_LEN     = 8;
  localparam int HOLDOFF_LEN = 4;
  localparam int MIN_OTHERS  = 2;

`ifdef COINC_MAJORITY_EN
  localparam logic [3:0] OV_CH0    = 4'b0000;
  localparam logic [3:0] OV_CH0_2  = 4'b1010;
  localparam logic [3:0] OV_CH2    = 4'b0000;
  localparam logic [3:0] OV_CH0_1  = 4'b1100;
`else
  localparam logic [3:0] OV_CH0    = 4'b1110;
  localparam logic [3:0] OV_CH0_2  = 4'b1111;
  localparam logic [3:0] OV_CH2    = 4'b1011;
  localparam logic [3:0] OV_CH0_1  = 4'b1111;
`endif

  typedef struct {
    int ch;
    int open_cycle;
  } exp_t;

  logic entry_clock = 1'b0;
  logic reset_n     = 1'b1;
  int   cyc         = 0;
  int   n_checks    = 0;
  int   n_pass      = 0;
  logic skip_len    = 1'b0;

  exp_t              exp_q[$];
  logic [NUM_CH-1:0] prev_win = '0;
  int                start_cyc [NUM_CH];

  coinc_window_gen_if #(.NUM_CH(NUM_CH)) bus ();

  coinc_window_gen #(
    .NUM_CH      (NUM_CH),
    .WIN_LEN     (WIN_LEN),
    .HOLDOFF_LEN (HOLDOFF_LEN),
    .MIN_OTHERS  (MIN_OTHERS)
  ) dut (
    .entry_clock (entry_clock),
    .reset_n     (reset_n),
    .bus         (bus)
  );

  always #5 entry_clock = ~entry_clock;

  always @(posedge entry_clock) cyc <= cyc + 1;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic wait_cycle(input int n);
    while (cyc < n) @(negedge entry_clock);
  endtask

  task automatic apply_stimulus(input logic [NUM_CH-1:0] valid);
    bus.chan_valid = valid;
  endtask

  task automatic expect_window(input int ch, input int open_cycle);
    exp_t e;
    e.ch         = ch;
    e.open_cycle = open_cycle;
    exp_q.push_back(e);
  endtask

  // Window monitor: every opening must match the oldest expected one and last WIN_LEN cycles.
  always @(negedge entry_clock) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.win_open[c] === 1'b1 && prev_win[c] === 1'b0) begin
        check_output("win_was_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check_output("win_channel", 32'(c), 32'(e.ch));
          check_output("win_open_cycle", 32'(cyc), 32'(e.open_cycle));
        end
        start_cyc[c] = cyc;
      end else if (bus.win_open[c] === 1'b0 && prev_win[c] === 1'b1 && !skip_len) begin
        check_output("win_length", 32'(cyc - start_cyc[c]), 32'(WIN_LEN));
      end
    end
    prev_win = bus.win_open;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int t0, t1, t2, t3, t4, r;

    bus.enable = 1'b1;
    apply_stimulus(4'b1111);
    #2 reset_n = 1'b0;
    #1;
    check_output("reset_win_open", 32'(bus.win_open), 32'd0);
    check_output("reset_other_valid", 32'(bus.other_valid), 32'd0);
    check_output("reset_coinc_count", 32'(bus.coinc_count), 32'd0);

    // Release with every chan_valid already high: no window may open.
    @(negedge entry_clock);
    @(negedge entry_clock);
    reset_n = 1'b1;
    repeat (4) @(negedge entry_clock);
    check_output("held_high_no_window", 32'(bus.win_open), 32'd0);
    apply_stimulus(4'b0000);
    repeat (3) @(negedge entry_clock);

    $display("[TB] single channel and dead time");
    t0 = cyc;
    wait_cycle(t0 + 9);  apply_stimulus(4'b0001); expect_window(0, t0 + 11);
    wait_cycle(t0 + 10); check_output("single_latency", 32'(bus.win_open), 32'd0);
    wait_cycle(t0 + 11); check_output("single_open", 32'(bus.win_open), 32'b0001);
    check_output("single_ov_latency", 32'(bus.other_valid), 32'd0);
    apply_stimulus(4'b0000);
    wait_cycle(t0 + 12); check_output("single_ov_first", 32'(bus.other_valid), 32'(OV_CH0));
    wait_cycle(t0 + 13); apply_stimulus(4'b0001);
    wait_cycle(t0 + 15); apply_stimulus(4'b0000);
    wait_cycle(t0 + 18); check_output("single_last_open", 32'(bus.win_open), 32'b0001);
    wait_cycle(t0 + 19); check_output("single_closed", 32'(bus.win_open), 32'd0);
    check_output("single_ov_last", 32'(bus.other_valid), 32'(OV_CH0));
    apply_stimulus(4'b0001);
    wait_cycle(t0 + 20); check_output("single_ov_cleared", 32'(bus.other_valid), 32'd0);
    apply_stimulus(4'b0000);
    wait_cycle(t0 + 22); apply_stimulus(4'b0001); expect_window(0, t0 + 24);
    wait_cycle(t0 + 23); check_output("holdoff_not_open", 32'(bus.win_open), 32'd0);
    wait_cycle(t0 + 24); check_output("reopen", 32'(bus.win_open), 32'b0001);
    apply_stimulus(4'b0000);
    wait_cycle(t0 + 31); check_output("reopen_last", 32'(bus.win_open), 32'b0001);
    wait_cycle(t0 + 32); check_output("reopen_closed", 32'(bus.win_open), 32'd0);
    check_output("single_no_coinc", 32'(bus.coinc_count), 32'd0);
    wait_cycle(t0 + 40);

    $display("[TB] two-channel overlap");
    t1 = cyc;
    wait_cycle(t1 + 9);  apply_stimulus(4'b0001); expect_window(0, t1 + 11);
    wait_cycle(t1 + 10); apply_stimulus(4'b0000);
    wait_cycle(t1 + 13); apply_stimulus(4'b0100); expect_window(2, t1 + 15);
    wait_cycle(t1 + 14); apply_stimulus(4'b0000);
    wait_cycle(t1 + 15); check_output("overlap_win", 32'(bus.win_open), 32'b0101);
    check_output("overlap_count_before", 32'(bus.coinc_count), 32'd0);
    wait_cycle(t1 + 16); check_output("overlap_count_onset", 32'(bus.coinc_count), 32'd1);
    check_output("overlap_ov", 32'(bus.other_valid), 32'(OV_CH0_2));
    wait_cycle(t1 + 19); check_output("overlap_ch2_only", 32'(bus.win_open), 32'b0100);
    wait_cycle(t1 + 20); check_output("ov_excludes_self", 32'(bus.other_valid), 32'(OV_CH2));
    wait_cycle(t1 + 30); check_output("overlap_count_once", 32'(bus.coinc_count), 32'd1);

    $display("[TB] saturation and simultaneous pair");
    t2 = cyc;
    force dut.coinc_q = 16'hFFFE;
    #1 release dut.coinc_q;
    wait_cycle(t2 + 1);  check_output("preload_hold", 32'(bus.coinc_count), 32'hFFFE);
    apply_stimulus(4'b0011); expect_window(0, t2 + 3); expect_window(1, t2 + 3);
    wait_cycle(t2 + 2);  apply_stimulus(4'b0000);
    wait_cycle(t2 + 4);  check_output("count_reaches_max", 32'(bus.coinc_count), 32'hFFFF);
    check_output("pair_ov", 32'(bus.other_valid), 32'(OV_CH0_1));
    wait_cycle(t2 + 20); apply_stimulus(4'b0011); expect_window(0, t2 + 22); expect_window(1, t2 + 22);
    wait_cycle(t2 + 21); apply_stimulus(4'b0000);
    wait_cycle(t2 + 24); check_output("count_saturated", 32'(bus.coinc_count), 32'hFFFF);
    wait_cycle(t2 + 40);

    $display("[TB] enable drop");
    t3 = cyc;
    wait_cycle(t3 + 1);  apply_stimulus(4'b0010); expect_window(1, t3 + 3);
    wait_cycle(t3 + 2);  apply_stimulus(4'b0000);
    wait_cycle(t3 + 4);  check_output("enable_win_before", 32'(bus.win_open), 32'b0010);
    skip_len = 1'b1;
    bus.enable = 1'b0;
    wait_cycle(t3 + 5);  check_output("enable_win_cleared", 32'(bus.win_open), 32'd0);
    check_output("enable_ov_cleared", 32'(bus.other_valid), 32'd0);
    check_output("enable_count_holds", 32'(bus.coinc_count), 32'hFFFF);
    bus.enable = 1'b1;
    wait_cycle(t3 + 7);  skip_len = 1'b0;
    wait_cycle(t3 + 8);  check_output("enable_stays_idle", 32'(bus.win_open), 32'd0);
    wait_cycle(t3 + 10);

    $display("[TB] reset abort mid-window");
    t4 = cyc;
    wait_cycle(t4 + 9);  apply_stimulus(4'b0001); expect_window(0, t4 + 11);
    wait_cycle(t4 + 10); apply_stimulus(4'b0000);
    wait_cycle(t4 + 14);
    skip_len = 1'b1;
    reset_n  = 1'b0;
    #1;
    check_output("abort_win_open", 32'(bus.win_open), 32'd0);
    check_output("abort_other_valid", 32'(bus.other_valid), 32'd0);
    check_output("abort_coinc_count", 32'(bus.coinc_count), 32'd0);
    wait_cycle(t4 + 15);
    reset_n = 1'b1;
    r = cyc;
    wait_cycle(r + 1);  apply_stimulus(4'b0001); expect_window(0, r + 3);
    wait_cycle(r + 2);  apply_stimulus(4'b0000); skip_len = 1'b0;
    wait_cycle(r + 3);  check_output("abort_new_window", 32'(bus.win_open), 32'b0001);
    wait_cycle(r + 10); check_output("abort_new_last", 32'(bus.win_open), 32'b0001);
    wait_cycle(r + 11); check_output("abort_new_closed", 32'(bus.win_open), 32'd0);
    wait_cycle(r + 20);

    check_output("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/coinc_window_gen.md
COINC_WINDOW_GEN -- requirements
Module: coinc_window_gen

Interface
REQ-001 Parameter NUM_CH, default 4: number of channels.
REQ-002 Parameter WIN_LEN, default 8: coincidence window length in entry_clock cycles, range 1..255.
REQ-003 Parameter HOLDOFF_LEN, default 4: post-window dead time in cycles, range 0..255.
REQ-004 Parameter MIN_OTHERS, default 2: number of other open windows required when COINC_MAJORITY_EN is defined, range 1..NUM_CH-1.
REQ-005 Port entry_clock  input  1  sole clock; all logic rising-edge.
REQ-006 Port reset_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-007 Port enable  input  1  1: window generation active.
REQ-008 Port chan_valid  input  NUM_CH  per-channel valid-sequence flag, level or pulse.
REQ-009 Port win_open  output  NUM_CH  per-channel coincidence window currently open.
REQ-010 Port other_valid  output  NUM_CH  per-channel "other channels valid" flag, feeds the coincidence checker.
REQ-011 Port coinc_count  output  16  saturating count of multi-channel overlap onsets.

Function
REQ-012 Each channel shall register chan_valid every cycle and detect a rising edge as chan_valid=1 with the previous sample=0.
REQ-013 Each channel shall run an FSM with states IDLE, OPEN and HOLDOFF, plus an 8-bit down-counter.
REQ-014 IDLE->OPEN on a detected edge with enable=1; win_open goes high the following cycle and stays high exactly WIN_LEN cycles.
REQ-015 OPEN->HOLDOFF after WIN_LEN cycles, or OPEN->IDLE if HOLDOFF_LEN=0; HOLDOFF->IDLE after HOLDOFF_LEN cycles.
REQ-016 Edges arriving in OPEN or HOLDOFF shall be ignored; the window is not extended and no edge is queued.
REQ-017 An edge in the same cycle the FSM returns to IDLE shall be ignored; the earliest accepted edge is the first cycle with state=IDLE.
REQ-018 other_valid[i] shall be registered from win_open and be 1 when at least THRESH bits of win_open[j], j!=i, are set, with a latency of 1 cycle after win_open.
REQ-019 other_valid[i] shall never depend on win_open[i].
REQ-020 coinc_count shall increment by 1 on each cycle where popcount(win_open)>=2 and the previous cycle's popcount was <2.
REQ-021 coinc_count shall saturate at 16'hFFFF.
REQ-022 enable=0 shall force all FSMs to IDLE and win_open/other_valid to 0 on the next edge; edge registers keep sampling and coinc_count holds its value.

Reset
REQ-023 reset_n=0 shall asynchronously clear win_open, other_valid, coinc_count, edge registers and counters, and place all FSMs in IDLE.
REQ-024 Reset asserted mid-window shall abort the window immediately with no holdoff afterwards.
REQ-025 A chan_valid already high at reset release shall not be treated as an edge.

Configuration
REQ-026 Macro COINC_MAJORITY_EN defined: THRESH=MIN_OTHERS.
REQ-027 Macro COINC_MAJORITY_EN undefined: THRESH=1 (any other open window) and MIN_OTHERS is ignored.

Structure
REQ-028 Shared package coinc_pkg shall hold the channel FSM state typedef (IDLE/OPEN/HOLDOFF), the counter width constant (8) and the coinc_count width constant (16).
REQ-029 Sub-module coinc_chan_fsm (edge detect, FSM, counter, win_open) shall be instantiated NUM_CH times; the threshold logic and coinc_count stay in the top level.

Verification (NUM_CH=4, WIN_LEN=8, HOLDOFF_LEN=4)
REQ-030 Reset: reset_n low -> all outputs 0 asynchronously; chan_valid=4'b1111 held through reset release -> no window opens.
REQ-031 Single channel: chan_valid[0] edge sampled at cycle 10 -> win_open[0]=1 for cycles 11..18; other_valid[3:1]=1 for cycles 12..19 (no macro); other_valid[0]=0 throughout.
REQ-032 Dead time: extra chan_valid[0] edges at 14 (OPEN) and 20 (HOLDOFF) -> ignored; edge at 23 -> win_open[0]=1 for cycles 24..31.
REQ-033 Overlap: ch0 edge at 10, ch2 edge at 14 -> popcount>=2 for cycles 15..18 -> coinc_count 0->1 exactly once; coinc_count preloaded via 65535 overlaps -> stays FFFF.
REQ-034 Majority: COINC_MAJORITY_EN, MIN_OTHERS=2; ch0 alone -> other_valid=0; ch0+ch1 at the same cycle -> other_valid=4'b1100 during the overlap.
REQ-035 Abort: reset_n low at cycle 14 during the ch0 window -> win_open/other_valid/coinc_count=0 immediately; ch0 edge at the cycle after release -> new window without holdoff.
